// File: rtl/signal_path_pkg.sv
// Shared types and arithmetic helpers for the multichannel FIR signal path.
package signal_path_pkg;

   typedef enum logic [1:0] {IDLE, MAC, DRAIN, DONE} fir_state_t;

   // Index width for an n-entry table, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int acc_w(input int data_w, input int coef_w, input int n_taps);
      return data_w + coef_w + $clog2(n_taps);
   endfunction

   // Q1.(coef_w-1) accumulator back to a data_w sample: round half up, then clamp.
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                    input int data_w,
                                                    input int coef_w);
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r  = (acc + (64'sd1 <<< (coef_w - 2))) >>> (coef_w - 1);
      hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (data_w - 1));
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
      return r;
   endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Coefficient register file: one write port, one combinational read port.
module fir_coeff_bank
   import signal_path_pkg::*;
#(
   parameter  int N_CH    = 3,
   parameter  int N_TAPS  = 16,
   parameter  int N_BANKS = 4,
   parameter  int COEF_W  = 16,
   localparam int CH_W    = idx_w(N_CH),
   localparam int BANK_W  = idx_w(N_BANKS),
   localparam int TAP_W   = idx_w(N_TAPS)
) (
   input  logic                     sys_clk,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [CH_W-1:0]          wr_ch,
   input  logic [BANK_W-1:0]        wr_bank,
   input  logic [TAP_W-1:0]         wr_tap,
   input  logic [COEF_W-1:0]        wr_value,
   input  logic [CH_W-1:0]          rd_ch,
   input  logic [BANK_W-1:0]        rd_bank,
   input  logic [TAP_W-1:0]         rd_tap,
   output logic signed [COEF_W-1:0] rd_coef
);

   logic signed [COEF_W-1:0] coef_q [N_CH][N_BANKS][N_TAPS];
   logic                     wr_hit;

   // Writes addressing a nonexistent channel/bank/tap are silently dropped.
   assign wr_hit = wr_en && (int'(wr_ch) < N_CH) && (int'(wr_bank) < N_BANKS)
                         && (int'(wr_tap) < N_TAPS);

   // NOTE: this storage is cleared by reset because filters must start from all-zero coefficients.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < N_CH; c++)
            for (int b = 0; b < N_BANKS; b++)
               for (int t = 0; t < N_TAPS; t++)
                  coef_q[c][b][t] <= '0;
      end else if (wr_hit) begin
         coef_q[wr_ch][wr_bank][wr_tap] <= wr_value;
      end
   end

   assign rd_coef = coef_q[rd_ch][rd_bank][rd_tap];

endmodule

// File: rtl/fir_multichannel_engine.sv
// N_CH-channel, N_TAPS-tap FIR with per-channel coefficient banks and one shared MAC.
module fir_multichannel_engine
   import signal_path_pkg::*;
#(
   parameter  int N_CH    = 3,
   parameter  int N_TAPS  = 16,
   parameter  int N_BANKS = 4,
   parameter  int DATA_W  = 16,
   parameter  int COEF_W  = 16,
   localparam int CH_W    = idx_w(N_CH),
   localparam int BANK_W  = idx_w(N_BANKS),
   localparam int TAP_W   = idx_w(N_TAPS)
) (
   input  logic                     sys_clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_CH*DATA_W-1:0]   in_data,
   input  logic [N_CH*BANK_W-1:0]   ch_bank,
   input  logic                     update_en,
   output logic                     update_ready,
   input  logic [CH_W-1:0]          update_ch,
   input  logic [BANK_W-1:0]        update_bank,
   input  logic [TAP_W-1:0]         update_index,
   input  logic [COEF_W-1:0]        update_value,
   output logic [N_CH*DATA_W-1:0]   out_data,
   output logic                     out_valid,
   output logic                     data_irq,
   input  logic                     irq_ack,
   output logic                     overrun,
   input  logic                     clr_overrun
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = acc_w(DATA_W, COEF_W, N_TAPS);

   fir_state_t               state_q, state_d;
   logic [CH_W-1:0]          ch_cnt_q;
   logic [TAP_W-1:0]         tap_cnt_q;
   logic [N_CH*BANK_W-1:0]   bank_lat_q;
   logic signed [DATA_W-1:0] dline_q [N_CH][N_TAPS];

   logic signed [PROD_W-1:0] prod_q;
   logic                     prod_vld_q, prod_first_q, prod_last_q;
   logic [CH_W-1:0]          prod_ch_q;
   logic signed [ACC_W-1:0]  acc_q, acc_sum;
   logic [N_CH*DATA_W-1:0]   out_data_q;
   logic                     data_irq_q, overrun_q;

   logic                     accept, last_pair, wr_en;
   logic [BANK_W-1:0]        bank_rd;
   logic signed [COEF_W-1:0] coef_rd;
   logic signed [DATA_W-1:0] sample_rd;

   assign accept    = in_valid && in_ready;
   assign last_pair = (int'(ch_cnt_q) == N_CH - 1) && (tap_cnt_q == TAP_W'(N_TAPS - 1));
   assign wr_en     = update_en && update_ready;
   assign bank_rd   = bank_lat_q[int'(ch_cnt_q)*BANK_W +: BANK_W];
   assign sample_rd = dline_q[ch_cnt_q][tap_cnt_q];

   fir_coeff_bank #(
      .N_CH    (N_CH),
      .N_TAPS  (N_TAPS),
      .N_BANKS (N_BANKS),
      .COEF_W  (COEF_W)
   ) u_coeff_bank (
      .sys_clk  (sys_clk),
      .reset_n  (reset_n),
      .wr_en    (wr_en),
      .wr_ch    (update_ch),
      .wr_bank  (update_bank),
      .wr_tap   (update_index),
      .wr_value (update_value),
      .rd_ch    (ch_cnt_q),
      .rd_bank  (bank_rd),
      .rd_tap   (tap_cnt_q),
      .rd_coef  (coef_rd)
   );

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      in_ready     = 1'b0;
      update_ready = 1'b0;
      out_valid    = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready     = 1'b1;
            update_ready = 1'b1;
            if (in_valid) state_d = MAC;
         end
         MAC:     if (last_pair) state_d = DRAIN;
         DRAIN:   state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         ch_cnt_q     <= '0;
         tap_cnt_q    <= '0;
         bank_lat_q   <= '0;
         prod_q       <= '0;
         prod_vld_q   <= 1'b0;
         prod_first_q <= 1'b0;
         prod_last_q  <= 1'b0;
         prod_ch_q    <= '0;
         for (int c = 0; c < N_CH; c++)
            for (int t = 0; t < N_TAPS; t++)
               dline_q[c][t] <= '0;
      end else begin
         state_q    <= state_d;
         prod_vld_q <= (state_q == MAC);
         if (accept) begin
            ch_cnt_q   <= '0;
            tap_cnt_q  <= '0;
            bank_lat_q <= ch_bank;
            for (int c = 0; c < N_CH; c++) begin
               dline_q[c][0] <= in_data[c*DATA_W +: DATA_W];
               for (int t = 1; t < N_TAPS; t++)
                  dline_q[c][t] <= dline_q[c][t-1];
            end
         end else if (state_q == MAC) begin
            prod_q       <= PROD_W'(sample_rd) * PROD_W'(coef_rd);
            prod_first_q <= (tap_cnt_q == '0);
            prod_last_q  <= (tap_cnt_q == TAP_W'(N_TAPS - 1));
            prod_ch_q    <= ch_cnt_q;
            if (tap_cnt_q == TAP_W'(N_TAPS - 1)) begin
               tap_cnt_q <= '0;
               ch_cnt_q  <= ch_cnt_q + 1'b1;
            end else begin
               tap_cnt_q <= tap_cnt_q + 1'b1;
            end
         end
      end
   end

   // The first product of a channel replaces the running sum rather than adding to it.
   assign acc_sum = prod_first_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q      <= '0;
         out_data_q <= '0;
      end else if (accept) begin
         acc_q <= '0;
      end else if (prod_vld_q) begin
         acc_q <= acc_sum;
         if (prod_last_q)
            out_data_q[int'(prod_ch_q)*DATA_W +: DATA_W] <=
               DATA_W'(round_sat(64'(acc_sum), DATA_W, COEF_W));
      end
   end

   // Sticky flags: a set in the same cycle as its clear takes priority.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         data_irq_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         data_irq_q <= (state_q == DONE) || (data_irq_q && !irq_ack);
         overrun_q  <= (in_valid && !in_ready) || (overrun_q && !clr_overrun);
      end
   end

   assign out_data = out_data_q;
   assign data_irq = data_irq_q;
   assign overrun  = overrun_q;

endmodule

// File: doc/fir_multichannel_engine.md
Name: fir_multichannel_engine

Overview:
Parametrised successor to the fixed 16-tap, 3-axis accelerometer filter path. It filters N_CH signed sample channels through N_TAPS-tap FIR filters and selects coefficients per channel from N_BANKS banks. A single time-multiplexed multiply-accumulate unit computes every channel. Coefficients can be rewritten at runtime, and results raise an interrupt-style flag for the Nios II CPU.

Parameters:
N_CH, 3, number of channels (x/y/z by default)
N_TAPS, 16, taps per filter
N_BANKS, 4, coefficient banks per channel
DATA_W, 16, signed sample/result width
COEF_W, 16, signed coefficient width, Q1.(COEF_W-1)

Ports:
sys_clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  new sample frame present
in_ready  out  1  engine idle, frame will be accepted
in_data  in  N_CH*DATA_W  channel c at [c*DATA_W +: DATA_W]
ch_bank  in  N_CH*BANK_W  bank select per channel, BANK_W=clog2(N_BANKS)
update_en  in  1  coefficient write strobe
update_ready  out  1  write accepted this cycle
update_ch  in  CH_W  target channel, CH_W=clog2(N_CH)
update_bank  in  BANK_W  target bank
update_index  in  TAP_W  target tap, TAP_W=clog2(N_TAPS)
update_value  in  COEF_W  coefficient value
out_data  out  N_CH*DATA_W  filtered results, held until next frame
out_valid  out  1  one-cycle pulse, new out_data
data_irq  out  1  sticky result-ready flag
irq_ack  in  1  clears data_irq
overrun  out  1  sticky frame-dropped flag
clr_overrun  in  1  clears overrun

Behaviour:
- Reset values: out_data=0, out_valid=0, data_irq=0, overrun=0, in_ready=1, update_ready=1. All delay lines and all coefficients are 0. State is IDLE.
- FSM states: IDLE -> MAC -> DRAIN -> DONE -> IDLE.
- IDLE: in_ready=1. When in_valid=1 (cycle 0):
  - every channel's delay line shifts (new sample goes to tap 0; the oldest sample is discarded);
  - ch_bank is latched for the whole frame;
  - accumulator is cleared;
  - state goes to MAC.
- MAC: lasts N_CH*N_TAPS cycles. Pairs are issued channel-major (ch 0 taps 0..N_TAPS-1, then ch 1, ...). The product is registered and accumulated one cycle later.
- Per-channel accumulator: ACC_W = DATA_W+COEF_W+clog2(N_TAPS), signed. It is cleared at each channel boundary.
- When a channel's last product accumulates:
  - result = (acc + 2^(COEF_W-2)) >>> (COEF_W-1) (arithmetic shift, round half up);
  - result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1];
  - result is written to that channel's out_data slot.
- DRAIN: one cycle, accumulates the final product.
- DONE: out_valid=1 for exactly one cycle, sets data_irq.
  - Latency: out_valid occurs in cycle N_CH*N_TAPS+2 relative to cycle 0.
  - in_ready returns to 1 the following cycle.
- out_data updates only within the frame. Individual slots may change before out_valid; consumers sample only on out_valid.
- in_valid while in_ready=0: frame dropped, delay lines untouched, overrun set.
- overrun clears on clr_overrun. If set and clear occur in the same cycle, set wins.
- data_irq clears on irq_ack. If DONE and irq_ack occur in the same cycle, data_irq stays 1.
- Coefficient writes:
  - update_ready = (state==IDLE). update_en while update_ready=0 is ignored; the master holds it.
  - An accepted write takes effect on the next clock edge and is visible to a frame accepted in the same cycle's successor.
  - update_ch>=N_CH or update_index>=N_TAPS: write ignored, no error.
  - Simultaneous in_valid and accepted write in IDLE: the frame starts, the write completes, and the frame uses the new value.
- Bank select changes during MAC/DRAIN/DONE do not affect the current frame.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is lost and out_valid is not generated.

Decomposition:
- Package signal_path_pkg holds:
  - state enum fir_state_t {IDLE, MAC, DRAIN, DONE};
  - width helper functions (clog2-based CH_W/BANK_W/TAP_W/ACC_W);
  - round/saturate function.
- Sub-module fir_coeff_bank: N_CH*N_BANKS*N_TAPS coefficient register file with one write port (update_*) and one combinational read port (ch, bank, tap). All other logic stays in fir_multichannel_engine.

Test Plan:
Bench config: N_CH=3, N_TAPS=4, N_BANKS=4, DATA_W=16, COEF_W=16. Latency is 14 cycles.
1. Reset, then frame {0x1000,0x1000,0x1000} with zero coefficients -> out_valid exactly 14 cycles after acceptance; out_data all 0; data_irq=1; in_ready=0 for cycles 1..14.
2. Ch0 bank0 coeffs {0x4000,0x2000,0,0}; ch0 samples 0x1000,0,0,0 -> ch0 outputs 0x0800, 0x0400, 0x0000, 0x0000. Rounding check: coeff0=0x0001, sample 0x4000 -> 0x0001.
3. All ch1 bank2 coeffs 0x7FFF, ch_bank[1]=2; four samples 0x7FFF -> 0x7FFF; four samples 0x8000 -> 0x8000 (saturation both ways).
4. ch_bank[0] switched 0->1 in cycle 5 of a frame -> that frame uses bank 0, the next uses bank 1. update_en during MAC -> update_ready=0, coefficient unchanged until IDLE.
5. in_valid at cycle 3 of a frame -> overrun=1; next output shows the dropped sample absent from the delay line. clr_overrun -> 0.
6. irq_ack held high in the DONE cycle -> data_irq remains 1. A single irq_ack afterwards -> 0. Reset asserted mid-MAC -> no out_valid, all outputs at reset values.
